// File: rtl/pio_button_pkg.sv
// Shared definitions for the debounced button PIO.
//   ADDR_*  : register word addresses on the Avalon-MM slave
//   clog2() : ceiling log2 with a minimum of 1, for sizing counters
package pio_button_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;  // debounced data (RO)
    localparam logic [2:0] ADDR_RAW  = 3'd1;  // synchronised raw input (RO)
    localparam logic [2:0] ADDR_MASK = 3'd2;  // irq_mask (RW)
    localparam logic [2:0] ADDR_EDGE = 3'd3;  // edge_capture (R, W1C)
    localparam logic [2:0] ADDR_RISE = 3'd4;  // rise_en (RW)
    localparam logic [2:0] ADDR_FALL = 3'd5;  // fall_en (RW)

    // Bits needed to hold values 0..value-1; never less than 1 so that a
    // degenerate counter still has a legal vector width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/pio_button_db_if.sv
// Avalon-MM register bus of the debounced button PIO.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (one cycle latency)
interface pio_button_db_if #(
    parameter int WIDTH = 4
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_debounce_chan.sv
// One input channel: two-flop synchroniser, tick-based debounce counter,
// debounced level and its one-cycle-delayed copy for edge detection.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : shared debounce tick from the prescaler
//   raw_in     : asynchronous input pin
//   sync       : synchronised input (second flop)
//   db         : debounced level
//   db_prev    : db delayed by one clock
module pio_debounce_chan
    import pio_button_pkg::*;
#(
    parameter int DB_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw_in,
    output logic sync,
    output logic db,
    output logic db_prev
);

    localparam int CW = clog2(DB_TICKS + 1);

    logic          meta;
    logic [CW-1:0] cnt;

    // NOTE: every register here is written with <= so all flops sample the
    // pre-edge values; blocking writes would let meta fall straight through
    // to sync in a single clock and defeat the synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            db      <= 1'b0;
            db_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            meta    <= raw_in;
            sync    <= meta;
            db_prev <= db;
            if (sync == db) begin
                // Input agrees with the debounced level (or bounced back):
                // any partial count is discarded.
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(DB_TICKS - 1)) begin
                    db  <= sync;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pio_button_db.sv
// Debounced button/switch PIO with per-channel edge capture and one level
// interrupt, as an Avalon-MM slave.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : register bus (slave modport)
//   in_port    : asynchronous raw inputs, one per channel
//   irq        : registered level interrupt, |(edge_capture & irq_mask)
module pio_button_db
    import pio_button_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               PRESCALE      = 50000,
    parameter int               DB_TICKS      = 10,
    parameter logic [WIDTH-1:0] RISE_EN_RESET = '1,
    parameter logic [WIDTH-1:0] FALL_EN_RESET = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_button_db_if.slave       bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam int PW = clog2(PRESCALE);

    logic [PW-1:0]    presc_cnt;
    logic             tick;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_prev;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] rd_mux;
    logic             wr;

    // Prescaler: with PRESCALE=1 the counter sits at 0 and tick is constant 1.
    assign tick = (presc_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) presc_cnt <= '0;
        else               presc_cnt <= presc_cnt + 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_debounce_chan #(
            .DB_TICKS (DB_TICKS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .raw_in  (in_port[i]),
            .sync    (sync[i]),
            .db      (db[i]),
            .db_prev (db_prev[i])
        );
    end

    assign wr       = bus.chipselect & ~bus.write_n;
    assign ev       = (db & ~db_prev & rise_en) | (~db & db_prev & fall_en);
    assign clr_mask = (wr && bus.address == ADDR_EDGE) ? bus.writedata : '0;

    // NOTE: rd_mux gets a default before the case so every path assigns it;
    // without that an unlisted address would infer a latch.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux = db;
            ADDR_RAW:  rd_mux = sync;
            ADDR_MASK: rd_mux = irq_mask;
            ADDR_EDGE: rd_mux = edge_capture;
            ADDR_RISE: rd_mux = rise_en;
            ADDR_FALL: rd_mux = fall_en;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= RISE_EN_RESET;
            fall_en      <= FALL_EN_RESET;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_MASK) irq_mask <= bus.writedata;
            if (wr && bus.address == ADDR_RISE) rise_en  <= bus.writedata;
            if (wr && bus.address == ADDR_FALL) fall_en  <= bus.writedata;
            // OR-ing ev after the clear makes a same-cycle set win.
            edge_capture <= (edge_capture & ~clr_mask) | ev;
            bus.readdata <= rd_mux;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_pio_button_db.sv
// Self-checking bench for pio_button_db. dut_a: PRESCALE=1, DB_TICKS=3;
// dut_b: PRESCALE=4, DB_TICKS=2. Read results go through a scoreboard
// queue: the expected value is pushed when the address is driven and
// popped when readdata for it appears one clock later.
module tb_pio_button_db;
    import pio_button_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_a;
    logic         reset_b;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         irq_a;
    logic         irq_b;

    int           checks   = 0;
    int           failures = 0;
    string        tag_q[$];
    logic [31:0]  exp_q[$];

    pio_button_db_if #(.WIDTH(W)) bus_a ();
    pio_button_db_if #(.WIDTH(W)) bus_b ();

    pio_button_db #(.WIDTH(W), .PRESCALE(1), .DB_TICKS(3)) dut_a (
        .clk     (clk),
        .reset   (reset_a),
        .bus     (bus_a),
        .in_port (in_a),
        .irq     (irq_a)
    );

    pio_button_db #(.WIDTH(W), .PRESCALE(4), .DB_TICKS(2)) dut_b (
        .clk     (clk),
        .reset   (reset_b),
        .bus     (bus_b),
        .in_port (in_b),
        .irq     (irq_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] expected);
        tag_q.push_back(tag);
        exp_q.push_back(expected);
    endtask

    task automatic sb_pop(input logic [31:0] observed);
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=0x%0h expected=none", observed);
        end else begin
            check(tag_q.pop_front(), observed, exp_q.pop_front());
        end
    endtask

    // Advance n clocks and settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int sel, input logic [2:0] addr, input logic [W-1:0] data);
        if (sel == 0) begin
            bus_a.address = addr; bus_a.writedata = data;
            bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end else begin
            bus_b.address = addr; bus_b.writedata = data;
            bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end
        step(1);
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    task automatic rd(input int sel, input logic [2:0] addr, input logic [W-1:0] expected,
                      input string tag);
        if (sel == 0) bus_a.address = addr;
        else          bus_b.address = addr;
        sb_push(tag, 32'(expected));
        step(1);
        sb_pop(sel == 0 ? 32'(bus_a.readdata) : 32'(bus_b.readdata));
    endtask

    initial begin
        int lat;

        reset_a = 1'b1; reset_b = 1'b1;
        in_a = '0; in_b = '0;
        bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;

        // ---- reset state ----
        step(2);
        check("rst_readdata", 32'(bus_a.readdata), 32'h0);
        check("rst_irq", 32'(irq_a), 32'h0);
        reset_a = 1'b0; reset_b = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(0, 3'(a), (a == 4) ? 4'hF : 4'h0, $sformatf("rst_addr%0d", a));
        end

        // ---- clean press on bit0: capture at edge 6, visible/irq at edge 7 ----
        wr(0, ADDR_MASK, 4'h1);
        bus_a.address = ADDR_EDGE;
        in_a = 4'h1;
        for (int c = 1; c <= 8; c++) begin
            sb_push($sformatf("press_edge_c%0d", c), (c >= 7) ? 32'h1 : 32'h0);
            step(1);
            sb_pop(32'(bus_a.readdata));
            check($sformatf("press_irq_c%0d", c), 32'(irq_a), (c >= 7) ? 32'h1 : 32'h0);
        end
        rd(0, ADDR_DATA, 4'h1, "press_db");
        rd(0, ADDR_RAW, 4'h1, "press_raw");
        wr(0, ADDR_EDGE, 4'h1);
        step(1);
        check("press_clear_irq", 32'(irq_a), 32'h0);

        // ---- bounce on bit2: 2-cycle pulses never satisfy DB_TICKS=3 ----
        wr(0, ADDR_MASK, 4'h5);
        for (int t = 0; t < 10; t++) begin
            in_a[2] = ~in_a[2];
            step(2);
            check($sformatf("bounce_irq_t%0d", t), 32'(irq_a), 32'h0);
        end
        rd(0, ADDR_DATA, 4'h1, "bounce_db");
        rd(0, ADDR_EDGE, 4'h0, "bounce_edge");
        in_a[2] = 1'b1;
        step(12);
        rd(0, ADDR_EDGE, 4'h4, "bounce_held_edge");
        rd(0, ADDR_DATA, 4'h5, "bounce_held_db");
        check("bounce_held_irq", 32'(irq_a), 32'h1);
        wr(0, ADDR_EDGE, 4'h4);
        step(12);
        rd(0, ADDR_EDGE, 4'h0, "bounce_once");

        // ---- falling edges and per-bit W1C ----
        wr(0, ADDR_RISE, 4'h0);
        wr(0, ADDR_FALL, 4'h2);
        wr(0, ADDR_MASK, 4'hF);
        rd(0, ADDR_FALL, 4'h2, "fall_en_rb");
        in_a = 4'h7;
        step(12);
        rd(0, ADDR_EDGE, 4'h0, "fall_rise_ignored");
        in_a = 4'hD;
        step(12);
        rd(0, ADDR_EDGE, 4'h2, "fall_capture");
        check("fall_irq", 32'(irq_a), 32'h1);
        wr(0, ADDR_EDGE, 4'h0);
        rd(0, ADDR_EDGE, 4'h2, "w1c_zero_noop");
        wr(0, ADDR_EDGE, 4'h2);
        check("w1c_irq_lag", 32'(irq_a), 32'h1);
        step(1);
        check("w1c_irq_low", 32'(irq_a), 32'h0);
        rd(0, ADDR_EDGE, 4'h0, "w1c_cleared");

        // ---- set/clear collision on bit0 ----
        wr(0, ADDR_RISE, 4'h1);
        in_a = 4'hC;
        step(12);
        rd(0, ADDR_EDGE, 4'h0, "collide_pre");
        in_a = 4'hD;
        step(5);
        wr(0, ADDR_EDGE, 4'h1);
        rd(0, ADDR_EDGE, 4'h1, "collide_set_wins");
        check("collide_irq", 32'(irq_a), 32'h1);

        // ---- prescaler (dut_b): db change 2+8 clocks after step, +-3 ----
        bus_b.address = ADDR_DATA;
        in_b = 4'h1;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (bus_b.readdata[0] && lat == 0) lat = c;
        end
        // readdata trails db by one clock, so db at 7..13 reads at 8..14.
        check("presc_latency_window", 32'(lat >= 8 && lat <= 14), 32'h1);
        rd(1, ADDR_EDGE, 4'h1, "presc_edge");
        in_b = 4'h0;
        step(30);
        wr(1, ADDR_EDGE, 4'h1);
        rd(1, ADDR_DATA, 4'h0, "presc_release");

        // ---- reset mid-debounce with input held high ----
        in_b = 4'h1;
        step(5);
        reset_b = 1'b1;
        step(1);
        reset_b = 1'b0;
        rd(1, ADDR_EDGE, 4'h0, "rst_mid_edge");
        bus_b.address = ADDR_DATA;
        for (int c = 2; c <= 6; c++) begin
            sb_push($sformatf("rst_mid_db_c%0d", c), 32'h0);
            step(1);
            sb_pop(32'(bus_b.readdata));
        end
        // Prescaler restarts at 0, so ticks land 4 and 8 clocks after the
        // reset edge; db flips at +8 and reads back at +9.
        lat = 0;
        for (int c = 7; c <= 40; c++) begin
            step(1);
            if (bus_b.readdata[0] && lat == 0) lat = c;
        end
        check("rst_mid_latency", 32'(lat), 32'd9);
        rd(1, ADDR_EDGE, 4'h1, "rst_mid_one_event");
        check("rst_mid_irq_masked", 32'(irq_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
